cla_seq_adder: RTL and testbench
================================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have in_valid, input, 1 bit: operand request valid.
REQ-005 The block SHALL have in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have in_a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have in_b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have in_sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-009 The block SHALL have out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have out_sum, output, WIDTH bits: result modulo 2^WIDTH.
REQ-012 The block SHALL have out_cout, output, 1 bit: carry out of the MSB (for sub, 1 = no borrow).
REQ-013 The block SHALL have out_ovf, output, 1 bit: signed overflow (see REQ-031).
REQ-014 The block SHALL have busy, output, 1 bit: high in RUN.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 SHALL latch in_a, in_b ^ {WIDTH{in_sub}}, carry=in_sub and nibble index 0, then enter RUN.
REQ-018 In RUN, each cycle SHALL process one 4-bit nibble k: P=a^b, G=a&b, four-bit lookahead carries from the current carry, sum nibble = P ^ {c2,c1,c0,carry}; the nibble is written to result bits [4k+3:4k] and the carry register is set to c3.
REQ-019 RUN SHALL last exactly WIDTH/4 cycles; after the last nibble the block SHALL enter DONE.
REQ-020 Latency from the accepting edge to out_valid=1 SHALL be WIDTH/4 + 1 cycles (9 for WIDTH=32).
REQ-021 In DONE, out_sum/out_cout/out_ovf SHALL stay stable until out_valid&out_ready, then the block SHALL return to IDLE.
REQ-022 in_valid outside IDLE SHALL be ignored; no request is queued.
REQ-023 Operand input changes after acceptance SHALL NOT affect the result.
REQ-024 Back-to-back throughput SHALL be one result per WIDTH/4 + 2 cycles when out_ready is held at 1.
REQ-025 WIDTH=4 SHALL use a single RUN cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, and clear the nibble index and carry.
REQ-027 Reset in RUN or DONE SHALL abort the operation; no result SHALL be produced.
REQ-028 The first request SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 The macro CLA_SEQ_ADDER_OVF_EN SHALL select whether overflow detection is compiled in.
REQ-030 Without CLA_SEQ_ADDER_OVF_EN, out_ovf SHALL be tied to 0 and no overflow logic SHALL exist.
REQ-031 With CLA_SEQ_ADDER_OVF_EN, out_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, captured in the last RUN cycle, valid in DONE, and reset to 0.

Verification
REQ-032 WIDTH=32: A=0x0000_0001, B=0x0000_0002, sub=0 -> out_valid after 9 cycles, sum=0x0000_0003, cout=0, ovf=0.
REQ-033 A=0xFFFF_FFFF, B=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1, ovf=0 (full carry ripple across all 8 nibbles).
REQ-034 A=0x7FFF_FFFF, B=0x0000_0001, sub=0 -> sum=0x8000_0000, cout=0, ovf=1 with macro and 0 without it.
REQ-035 A=0x0000_0005, B=0x0000_0007, sub=1 -> sum=0xFFFF_FFFE, cout=0; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-036 Assert rst_n=0 in the 4th RUN cycle -> outputs return immediately to reset values and no out_valid appears; a following request A=3, B=4 yields sum=7.
REQ-037 Pulse in_valid during RUN with different operands -> result matches the original operands only.

Source files
------------

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//   Sequential add/subtract unit. One 4-bit carry-lookahead slice is reused
//   across the operand, one nibble per clock, LSB nibble first. Subtraction
//   is A + ~B + 1, with the inversion and carry-in applied at acceptance.
//
//   Optional feature: define CLA_SEQ_ADDER_OVF_EN to build signed-overflow
//   detection. Without it out_ovf is a constant 0 and no overflow logic exists.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (ready only when idle)
//   in_a, in_b, in_sub      operands; in_sub=1 selects A-B
//   out_valid / out_ready   result handshake (valid only when done)
//   out_sum                 result modulo 2^WIDTH
//   out_cout                carry out of the MSB (sub: 1 = no borrow)
//   out_ovf                 signed overflow (0 unless CLA_SEQ_ADDER_OVF_EN)
//   busy                    high while nibbles are being processed
// ---------------------------------------------------------------------------
module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;

    logic              accept;
    logic              last_nib;
    logic [3:0]        a_nib, b_nib, p, g, c, s;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_nib = (idx_q == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
    end

    // ---------------- 4-bit lookahead slice ----------------
    // c[k] is the carry out of bit k of the current nibble; c[3] feeds the
    // next nibble through carry_q.
    always_comb begin
        a_nib = a_q[idx_q*4 +: 4];
        b_nib = b_q[idx_q*4 +: 4];
        p     = a_nib ^ b_nib;
        g     = a_nib & b_nib;
        c[0]  = g[0] | (p[0] & carry_q);
        c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
        c[3]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s     = p ^ {c[2:0], carry_q};
    end

    // ---------------- Datapath ----------------
    // Operands are captured once at acceptance, so later input changes
    // cannot reach the result. B is stored pre-inverted for subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b ^ {WIDTH{in_sub}};
            sum_q   <= '0;
            carry_q <= in_sub;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*4 +: 4] <= s;
            carry_q             <= c[3];
            idx_q               <= last_nib ? '0 : idx_q + 1'b1;
        end
    end

    assign out_sum  = sum_q;
    // After the last nibble the running carry is the MSB carry-out.
    assign out_cout = carry_q;

`ifdef CLA_SEQ_ADDER_OVF_EN
    // Signed overflow: carry into MSB (c[2]) xor carry out of MSB (c[3])
    // of the top nibble, captured while that nibble is processed.
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           ovf_q <= 1'b0;
        else if (accept)                      ovf_q <= 1'b0;
        else if ((state_q == RUN) && last_nib) ovf_q <= c[2] ^ c[3];
    end
    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder
//   Directed-vector bench for cla_seq_adder (WIDTH=32). Inputs are driven and
//   outputs sampled on the falling clock edge. Expected overflow follows the
//   CLA_SEQ_ADDER_OVF_EN macro.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;

    localparam int W = 32;
`ifdef CLA_SEQ_ADDER_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout, out_ovf, busy;

    int n_vec = 0;
    int n_err = 0;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Cycle count includes the accepting
    // cycle, so the result shows up with cyc == 9 for 32-bit operands.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sub, input logic [W-1:0] es, input bit ec, input bit eo,
                          input int hold, input bit poke);
        int cyc;
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        @(negedge clk);
        in_valid = 1'b0;
        if (poke) begin
            in_valid = 1'b1; in_a = ~a; in_b = 32'h5555_5555; in_sub = ~sub;
        end
        cyc = 1;
        chk({tag, ".busy"}, busy, 1);
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a = $urandom; in_b = $urandom; in_sub = 1'b0;
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 9);
        chk({tag, ".sum"},  out_sum,  es);
        chk({tag, ".cout"}, out_cout, ec);
        chk({tag, ".ovf"},  out_ovf,  eo & OVF);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_sum"},   out_sum,   es);
            chk({tag, ".hold_cout"},  out_cout,  ec);
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_ready"}, in_ready,  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".idle_ready"}, in_ready,  1);
        chk({tag, ".idle_valid"}, out_valid, 0);
    endtask

    initial begin
        int  cnt;
        bit  seen;
        logic [W-1:0] got;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst.in_ready",  in_ready,  1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy",      busy,      0);
        chk("rst.sum",       out_sum,   0);
        chk("rst.cout",      out_cout,  0);
        chk("rst.ovf",       out_ovf,   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // first request accepted on the first rising edge out of reset
        run_op("add_1_2",   32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 0, 1'b0);
        run_op("add_ripple",32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
        run_op("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5, 1'b0);
        run_op("sub_7_5",   32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
        run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("poke_run",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, 1'b1);

        // reset in the 4th RUN cycle aborts the operation
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h0101_0101; in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort.in_ready",  in_ready,  1);
        chk("abort.out_valid", out_valid, 0);
        chk("abort.busy",      busy,      0);
        chk("abort.sum",       out_sum,   0);
        chk("abort.cout",      out_cout,  0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort.no_result", seen, 0);
        run_op("after_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 0, 1'b0);

        // back-to-back throughput with out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h0000_000A; in_b = 32'h0000_0005; in_sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1; got = '0;
        while (!in_ready && cnt < 40) begin
            @(negedge clk);
            if (out_valid) got = out_sum;
            cnt++;
        end
        chk("b2b.period", cnt, 10);
        chk("b2b.sum",    got, 32'h0000_000F);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
